// File: rtl/updown_counter_n.sv
// Parametrised up/down counter over 0..MAX with wrap or saturate at the limits,
// synchronous clear, clamped parallel load and registered overflow/underflow pulses.
module updown_counter_n #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX      = 2**WIDTH - 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  input  logic             E,
  input  logic             F,
  output logic [WIDTH-1:0] y_out,
  output logic             ovf,
  output logic             unf,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

  logic [WIDTH-1:0] y_q, y_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] cur;

  // An out-of-range count (unreachable) is treated as MAX when counting.
  assign cur = (y_q > MaxVal) ? MaxVal : y_q;

  always_comb begin
    y_d   = y_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (clr) begin
      y_d = '0;
    end else if (load) begin
      y_d = (d_in > MaxVal) ? MaxVal : d_in;
    end else if (E) begin
      if (F) begin
        if (cur == MaxVal) begin
          ovf_d = 1'b1;
          y_d   = SATURATE ? MaxVal : '0;
        end else begin
          y_d = cur + WIDTH'(1);
        end
      end else begin
        if (cur == '0) begin
          unf_d = 1'b1;
          y_d   = SATURATE ? '0 : MaxVal;
        end else begin
          y_d = cur - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y_q   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign y_out  = y_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
  assign at_max = (y_q == MaxVal);
  assign at_min = (y_q == '0);

endmodule

// File: tb/tb_updown_counter_n.sv
// Scoreboard bench: three counter configurations share one stimulus stream; expected
// responses from an arithmetic reference model are queued and checked by a monitor.
module tb_updown_counter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, clr, load, e, f;
  logic [3:0] d_in;
  logic [3:0] y0, y1;
  logic [2:0] y2;
  logic       ovf0, unf0, amax0, amin0;
  logic       ovf1, unf1, amax1, amin1;
  logic       ovf2, unf2, amax2, amin2;

  updown_counter_n #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_wrap9 (
    .clk(clk), .rstn(rstn), .clr(clr), .load(load), .d_in(d_in), .E(e), .F(f),
    .y_out(y0), .ovf(ovf0), .unf(unf0), .at_max(amax0), .at_min(amin0)
  );

  updown_counter_n #(.WIDTH(4), .MAX(9), .SATURATE(1'b1)) u_sat9 (
    .clk(clk), .rstn(rstn), .clr(clr), .load(load), .d_in(d_in), .E(e), .F(f),
    .y_out(y1), .ovf(ovf1), .unf(unf1), .at_max(amax1), .at_min(amin1)
  );

  updown_counter_n #(.WIDTH(3)) u_full7 (
    .clk(clk), .rstn(rstn), .clr(clr), .load(load), .d_in(d_in[2:0]), .E(e), .F(f),
    .y_out(y2), .ovf(ovf2), .unf(unf2), .at_max(amax2), .at_min(amin2)
  );

  typedef struct {
    int y;
    bit o;
    bit u;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   m_y[3];
  int   checks   = 0;
  int   failures = 0;

  // Reference: counting is plain modular arithmetic over MAX+1 values, or clamping.
  function automatic exp_t model_step(int y, int max, bit sat, bit c, bit l, int d,
                                      bit en, bit up);
    exp_t r;
    r.y = y;
    r.o = 1'b0;
    r.u = 1'b0;
    if (c) begin
      r.y = 0;
    end else if (l) begin
      r.y = (d > max) ? max : d;
    end else if (en && up) begin
      r.o = (y == max);
      r.y = sat ? ((y == max) ? max : y + 1) : (y + 1) % (max + 1);
    end else if (en) begin
      r.u = (y == 0);
      r.y = sat ? ((y == 0) ? 0 : y - 1) : (y + max) % (max + 1);
    end
    return r;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(string tag, exp_t x, int max, int y, bit o, bit u, bit am,
                           bit an);
    check({tag, ".y_out"}, y, x.y);
    check({tag, ".ovf"}, int'(o), int'(x.o));
    check({tag, ".unf"}, int'(u), int'(x.u));
    check({tag, ".at_max"}, int'(am), int'(x.y == max));
    check({tag, ".at_min"}, int'(an), int'(x.y == 0));
  endtask

  task automatic check_reset(string tag);
    exp_t z;
    z.y = 0;
    z.o = 1'b0;
    z.u = 1'b0;
    check_out({tag, ".wrap9"}, z, 9, int'(y0), ovf0, unf0, amax0, amin0);
    check_out({tag, ".sat9"}, z, 9, int'(y1), ovf1, unf1, amax1, amin1);
    check_out({tag, ".full7"}, z, 7, int'(y2), ovf2, unf2, amax2, amin2);
  endtask

  // Inputs change on the falling edge; the expected result of the next rising edge is queued.
  task automatic drive(bit c, bit l, int d, bit en, bit up);
    exp_t x;
    @(negedge clk);
    rstn = 1'b1;
    clr  = c;
    load = l;
    d_in = 4'(d);
    e    = en;
    f    = up;
    x = model_step(m_y[0], 9, 1'b0, c, l, d, en, up);
    m_y[0] = x.y;
    q0.push_back(x);
    x = model_step(m_y[1], 9, 1'b1, c, l, d, en, up);
    m_y[1] = x.y;
    q1.push_back(x);
    x = model_step(m_y[2], 7, 1'b0, c, l, d % 8, en, up);
    m_y[2] = x.y;
    q2.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        x = q0.pop_front();
        check_out("wrap9", x, 9, int'(y0), ovf0, unf0, amax0, amin0);
      end
      if (q1.size() > 0) begin
        x = q1.pop_front();
        check_out("sat9", x, 9, int'(y1), ovf1, unf1, amax1, amin1);
      end
      if (q2.size() > 0) begin
        x = q2.pop_front();
        check_out("full7", x, 7, int'(y2), ovf2, unf2, amax2, amin2);
      end
      check("ovf_unf_exclusive", int'((ovf0 & unf0) | (ovf1 & unf1) | (ovf2 & unf2)), 0);
    end
  end

  initial begin : stimulus
    rstn = 1'b0;
    clr  = 1'b0;
    load = 1'b0;
    d_in = '0;
    e    = 1'b1;
    f    = 1'b1;
    for (int i = 0; i < 3; i++) m_y[i] = 0;

    // Held in reset with counting requested and the clock running.
    repeat (3) begin
      @(negedge clk);
      f = ~f;
      @(posedge clk);
      #1;
      check_reset("in_reset");
    end

    // Count to 5, then reset asynchronously between edges.
    repeat (5) drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_reset("async_reset");
    for (int i = 0; i < 3; i++) m_y[i] = 0;
    @(posedge clk);
    #1;
    check_reset("reset_edge");

    repeat (12) drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
    repeat (5) drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 9, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 0, 1'b0, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 13, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 6, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 15, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
    repeat (8) drive(1'b0, 1'b0, 0, 1'b1, 1'b1);

    repeat (200) begin
      drive(($urandom_range(15) == 0), ($urandom_range(7) == 0), int'($urandom_range(15)),
            1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    e = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", q0.size() + q1.size() + q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updown_counter_n.md
Name: updown_counter_n

Overview:
- Parametrised up/down counter; successor to the two-bit E/F-controlled counter exercise.
- Generalised count width and modulus, selectable wrap or saturate mode.
- Adds synchronous clear, parallel load, and registered overflow/underflow pulses.
- Used as a loadable event/position counter in the chapter-5 sequential designs.

Parameters:
- WIDTH, 4, counter width in bits (>=2).
- MAX, 2**WIDTH-1, highest count value; count range is 0..MAX. Must satisfy 1 <= MAX <= 2**WIDTH-1.
- SATURATE, 0, 0 = wrap at limits; 1 = hold at limits.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous reset, active-low.
- clr  input  1  synchronous clear.
- load  input  1  synchronous parallel load.
- d_in  input  WIDTH  load value.
- E  input  1  count enable.
- F  input  1  direction: 1 = up, 0 = down.
- y_out  output  WIDTH  registered count.
- ovf  output  1  registered one-cycle pulse on up-count at MAX.
- unf  output  1  registered one-cycle pulse on down-count at 0.
- at_max  output  1  combinational, y_out == MAX.
- at_min  output  1  combinational, y_out == 0.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rstn). All state updates on the rising clk edge, except reset.
- rstn=0: immediately y_out=0, ovf=0, unf=0, regardless of clk. All other inputs are ignored while rstn=0.
- After rstn deasserts, the first rising edge is evaluated normally.
- Priority per edge: clr > load > count (E) > hold.
  - clr=1: y_out<=0; ovf<=0; unf<=0.
  - load=1 (clr=0): y_out <= d_in if d_in <= MAX, else MAX (clamped); ovf<=0; unf<=0.
  - E=1, F=1, y_out<MAX: y_out<=y_out+1.
  - E=1, F=1, y_out==MAX: ovf<=1; y_out<=0 if SATURATE=0, else y_out<=MAX.
  - E=1, F=0, y_out>0: y_out<=y_out-1.
  - E=1, F=0, y_out==0: unf<=1; y_out<=MAX if SATURATE=0, else y_out<=0.
  - E=0: y_out holds.
- ovf and unf are 0 on every edge not listed above as setting them. They are pulses aligned with the cycle in which the new y_out is visible (latency 1 edge); they are never both 1.
- Counting latency: one edge per step; y_out changes by at most 1 per enabled edge.
- Arithmetic is modulo MAX+1 in wrap mode, never modulo 2**WIDTH unless MAX = 2**WIDTH-1. y_out never exceeds MAX.
- at_max and at_min follow y_out combinationally; both are 0 when 0 < y_out < MAX.
- Out-of-range state (not reachable) is treated as MAX on the next count edge.

Test Plan:
- Reset: WIDTH=4, MAX=9, SATURATE=0. Hold rstn=0 for 10 ns with E=1, F=1 toggling and clk running -> y_out=0, ovf=0, unf=0, at_min=1 throughout. Assert rstn=0 mid-count at y_out=5 -> y_out=0 immediately, without waiting for an edge.
- Up wrap: rstn=1, E=1, F=1 for 12 edges -> y_out = 1..9, 0, 1, 2; ovf=1 only on the cycle showing 0; at_max=1 while y_out=9.
- Down wrap: from 0, E=1, F=0 for 3 edges -> y_out = 9, 8, 7; unf=1 only on the cycle showing 9. Then E=0 for 5 edges -> y_out holds at 7, flags 0.
- Saturate: SATURATE=1, MAX=9. Load 9, then E=1, F=1 for 3 edges -> y_out stays 9, ovf=1 each edge. Load 0, then E=1, F=0 for 2 edges -> y_out stays 0, unf=1 each edge.
- Load/clear priority:
  - d_in=13, load=1 -> y_out=9 (clamped).
  - d_in=4, load=1, E=1, F=1 -> y_out=4, no increment.
  - clr=1, load=1, d_in=6 -> y_out=0.
- Full-range default: WIDTH=3, MAX=7. 8 up-edges from 0 -> y_out returns to 0, ovf pulses exactly once. Random E/F for 200 edges checked against a reference model.
